// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory boot loader.
//   state_t    - loader FSM states
//   HDR_BYTES  - bytes in the frame header (16-bit word count)
//   WORD_BYTES - bytes per instruction word
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  localparam int HDR_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// word_assembler: 8->32 big-endian byte packer.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clear       - discard any partially assembled word
//   byte_en     - a byte is being accepted this cycle
//   byte_data   - the accepted byte
//   word_data   - assembled word (valid when word_valid is high)
//   word_valid  - high in the cycle the last byte of a word is accepted
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_data,
  output logic        word_valid
);

  localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

  // Only the first three bytes need storage; the fourth arrives on the
  // cycle the word is handed out.
  logic [23:0] shreg_p0;
  logic [1:0]  byte_cnt_p0;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shreg_p0    <= '0;
      byte_cnt_p0 <= '0;
    end else if (byte_en) begin
      shreg_p0    <= {shreg_p0[15:0], byte_data};
      byte_cnt_p0 <= byte_cnt_p0 + 2'd1;
    end
  end

  assign word_data  = {shreg_p0, byte_data};
  assign word_valid = byte_en && (byte_cnt_p0 == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that streams a program into instruction memory
// while the CPU is held, then releases it.
// Frame: 16-bit word count N (MSB first), then N big-endian 32-bit words.
// Ports:
//   clk, rst_n    - clock, synchronous active-low reset
//   in_data/in_valid/in_ready - byte stream handshake
//   reload        - restart loading from DONE or ERROR
//   imem_wr_en/imem_wr_addr/imem_wr_data - one-cycle word write port
//   cpu_hold      - hold the datapath while loading or on error
//   done, err     - load complete / header count too large
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        reload,
  output logic        imem_wr_en,
  output logic [31:0] imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  state_t      state;
  logic [7:0]  count_hi;
  logic [15:0] word_count;
  logic [15:0] word_index;
  logic        accept;
  logic [15:0] hdr_count;
  logic [31:0] asm_word;
  logic        asm_valid;

  assign accept    = in_valid && in_ready;
  assign hdr_count = {count_hi, in_data};

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state != DATA),
    .byte_en    (accept && (state == DATA)),
    .byte_data  (in_data),
    .word_data  (asm_word),
    .word_valid (asm_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= HDR_HI;
      count_hi     <= '0;
      word_count   <= '0;
      word_index   <= '0;
      in_ready     <= 1'b1;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      imem_wr_en   <= 1'b0;
      imem_wr_addr <= BASE_ADDR;
      imem_wr_data <= '0;
    end else begin
      imem_wr_en <= 1'b0;
      case (state)
        HDR_HI: begin
          if (accept) begin
            count_hi <= in_data;
            state    <= HDR_LO;
          end
        end

        HDR_LO: begin
          if (accept) begin
            word_count <= hdr_count;
            word_index <= '0;
            if (hdr_count == 16'd0) begin
              state    <= DONE;
              in_ready <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end else if ({16'd0, hdr_count} > MAX_W) begin
              state    <= ERROR;
              in_ready <= 1'b0;
              err      <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (asm_valid) begin
            imem_wr_en   <= 1'b1;
            imem_wr_data <= asm_word;
            imem_wr_addr <= BASE_ADDR + {14'd0, word_index, 2'b00};
            word_index   <= word_index + 16'd1;
            // Release in the same cycle the last write is presented.
            if (word_index == word_count - 16'd1) begin
              state    <= DONE;
              in_ready <= 1'b0;
              cpu_hold <= 1'b0;
              done     <= 1'b1;
            end
          end
        end

        DONE: begin
          if (reload) begin
            state      <= HDR_HI;
            in_ready   <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            word_index <= '0;
          end
        end

        ERROR: begin
          if (reload) begin
            state      <= HDR_HI;
            in_ready   <= 1'b1;
            err        <= 1'b0;
            word_index <= '0;
          end
        end

        default: begin
          state    <= HDR_HI;
          in_ready <= 1'b1;
          cpu_hold <= 1'b1;
          done     <= 1'b0;
          err      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes a MIPS program into the instruction memory while the datapath is held off. It consumes a byte stream (from a UART/host bridge) over a valid/ready handshake, assembles big-endian 32-bit instruction words and drives a single-cycle word write port into instruction memory. It releases the CPU when the load completes. It sits beside the datapath: the datapath reads instruction memory, and this block is the writer at the other end of that same memory.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first instruction written. Must be word aligned.
- MAX_WORDS, 256: capacity of instruction memory in words. A header count above this value is an error.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts the byte this cycle
- reload  in  1  single-cycle pulse; restarts loading from DONE or ERROR
- imem_wr_en  out  1  instruction-memory write strobe, one cycle per word
- imem_wr_addr  out  32  byte address: BASE_ADDR + 4*word_index
- imem_wr_data  out  32  assembled instruction word
- cpu_hold  out  1  1 = datapath PC frozen / held in reset
- done  out  1  level; load completed successfully
- err  out  1  level; header count exceeded MAX_WORDS

## Operation
- A byte transfers only on a cycle where in_valid && in_ready are both high.
- Frame format: a 16-bit word count N (high byte first), then N×4 instruction bytes, each word most significant byte first.
- States:
  - HDR_HI: capture count[15:8], then go to HDR_LO.
  - HDR_LO: capture count[7:0]. If N==0, go to DONE. If N>MAX_WORDS, go to ERROR. Otherwise go to DATA with word_index=0 and byte_index=0.
  - DATA: shift each byte into a 32-bit assembly register; byte_index counts 0..3. On byte_index==3:
    - register the write: wr_data = assembled word, wr_addr = BASE_ADDR + 4*word_index.
    - increment word_index.
    - if this was word N-1, go to DONE.
  - DONE: in_ready=0, cpu_hold=0, done=1. reload returns to HDR_HI.
  - ERROR: in_ready=0, cpu_hold=1, err=1. reload returns to HDR_HI and clears err.
- in_ready=1 in HDR_HI, HDR_LO and DATA. There is no internal backpressure, so sustained throughput is one byte per cycle.
- word_index is a 16-bit counter. wr_addr arithmetic is 32-bit modulo 2^32, with word_index zero-extended and shifted left by 2.
- Bytes offered in DONE or ERROR are not consumed.

## Timing
- Reset values: state=HDR_HI, in_ready=1, cpu_hold=1, done=0, err=0, imem_wr_en=0, imem_wr_addr=BASE_ADDR, imem_wr_data=0, all counters 0.
- Write latency: imem_wr_en is high for exactly the one cycle after the 4th byte of a word is accepted. Address and data are stable in that cycle.
- A new byte may be accepted in the same cycle that imem_wr_en is high.
- Release latency: done=1 and cpu_hold=0 in the same cycle as the last word's imem_wr_en. Instruction memory writes are combinational-read, so the datapath's first fetch on the next edge sees the final word.
- N==0: done and cpu_hold=0 one cycle after the HDR_LO byte is accepted, with no writes.
- ERROR is entered one cycle after the HDR_LO byte is accepted, with no writes.
- reload is honoured only in DONE or ERROR and is ignored elsewhere.
  - On reload, the next cycle is HDR_HI with cpu_hold=1 and done=0; in_ready was 0 during the reload cycle.
- rst_n low in any state forces reset values on the next edge. A partial word is discarded and imem_wr_en is 0. Memory contents already written are untouched.

## Structure
- Shared package imem_loader_pkg holds:
  - the state enumeration (HDR_HI, HDR_LO, DATA, DONE, ERROR)
  - header width constant HDR_BYTES=2
  - constant WORD_BYTES=4
- One natural sub-module, word_assembler: an 8→32 big-endian shift register with a 2-bit byte counter and a word_valid output. The FSM owns the header, counters, address and handshake.
- The datapath top later gates PC update with cpu_hold and muxes the instruction-memory write port.

## Test plan
- Reset, then send 00 02 | 20 08 00 05 | 01 09 50 20:
  - writes 32'h20080005 @0x0 and 32'h01095020 @0x4, each with a single-cycle wr_en.
  - done=1 and cpu_hold=0 in the second write's cycle.
- Header 00 00 → no wr_en; done=1 one cycle after the second byte.
- Header 01 01 with MAX_WORDS=256 → err=1, cpu_hold=1, in_ready=0, no writes. Then reload → HDR_HI with err=0.
- One-byte-per-cycle stream with in_valid stalls inserted randomly → identical writes and addresses to the unstalled run.
- Send 00 01 20 08, then pulse rst_n low → no write. A fresh 00 01 AA BB CC DD writes 32'hAABBCCDD @BASE_ADDR.
- BASE_ADDR=0x400, N=3 → addresses 0x400, 0x404, 0x408. In DONE, reload plus a new frame rewrites from 0x400.
